// File: rtl/memstream_if.sv
// Bundle between the credit arbiter, the shared weight-memory read port
// and the per-stream consumers.
interface memstream_if #(
  parameter int unsigned NSTREAMS = 4,
  parameter int unsigned AWIDTH   = 14,
  parameter int unsigned DWIDTH   = 32
);
  logic                mem_en;
  logic [AWIDTH-1:0]   mem_addr;
  logic [DWIDTH-1:0]   mem_rdata;
  logic [NSTREAMS-1:0] credit_ret;
  logic [NSTREAMS-1:0] out_valid;
  logic [DWIDTH-1:0]   out_data;
  logic [NSTREAMS-1:0] credit_err;

  modport master (
    output mem_en, mem_addr, out_valid, out_data, credit_err,
    input  mem_rdata, credit_ret
  );

  modport slave (
    input  mem_en, mem_addr, out_valid, out_data, credit_err,
    output mem_rdata, credit_ret
  );
endinterface

// File: rtl/memstream_credit_arbiter.sv
// Round-robin, credit-gated sharing of one synchronous-read memory port between
// NSTREAMS cyclic segment readers, with a tag pipeline steering returned words.
module memstream_credit_arbiter #(
  parameter int unsigned NSTREAMS = 4,
  parameter int unsigned AWIDTH   = 14,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned CREDITS  = 4,
  parameter logic [NSTREAMS*AWIDTH-1:0] OFFSETS = '0,
  parameter logic [NSTREAMS*AWIDTH-1:0] DEPTHS  = {NSTREAMS{AWIDTH'(1)}}
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic        run,
  input  logic        restart,
  output logic        idle,
  memstream_if.master bus
);

  localparam int unsigned IW = (NSTREAMS > 1) ? $clog2(NSTREAMS) : 1;
  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  function automatic logic [AWIDTH-1:0] seg_base(input int unsigned i);
    return OFFSETS[i*AWIDTH +: AWIDTH];
  endfunction

  function automatic logic [AWIDTH-1:0] seg_last(input int unsigned i);
    return OFFSETS[i*AWIDTH +: AWIDTH] + DEPTHS[i*AWIDTH +: AWIDTH] - AWIDTH'(1);
  endfunction

  logic [CW-1:0]       credit [NSTREAMS];
  logic [AWIDTH-1:0]   addr   [NSTREAMS];
  logic [IW-1:0]       rr;
  logic [IW-1:0]       grant_id;
  logic                grant_any;
  logic                restart_apply;
  logic                busy_next;
  logic [IW:0]         cand;
  logic [NSTREAMS-1:0] elig;
  logic [NSTREAMS-1:0] issue;
  logic [NSTREAMS-1:0] ret_onehot;
  logic [RD_LAT-1:0]   tag_v;
  logic [IW-1:0]       tag_id [RD_LAT];
  logic [DWIDTH-1:0]   rdata;

  // Returned word goes straight through; only its owner is tracked here.
  assign rdata        = bus.mem_rdata;
  assign bus.out_data = rdata;

  // Eligibility: restart is only honoured when paused and drained.
  always_comb begin
    restart_apply = restart & idle & ~run;
    elig          = '0;
    for (int unsigned i = 0; i < NSTREAMS; i++) begin
      elig[i] = run & (credit[i] != '0) & ~restart_apply;
    end
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = rr;
    cand      = '0;
    for (int unsigned k = 1; k <= NSTREAMS; k++) begin
      cand = (IW+1)'(rr) + (IW+1)'(k);
      if (cand >= (IW+1)'(NSTREAMS)) begin
        cand = cand - (IW+1)'(NSTREAMS);
      end
      if (!grant_any && elig[cand[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    issue = '0;
    if (grant_any) begin
      issue[grant_id] = 1'b1;
    end
    ret_onehot = '0;
    if (tag_v[RD_LAT-1]) begin
      ret_onehot[tag_id[RD_LAT-1]] = 1'b1;
    end
    // Anything in the next cycle's tag pipeline (including a new issue) keeps us busy.
    busy_next = grant_any;
    for (int k = 0; k < int'(RD_LAT) - 1; k++) begin
      busy_next = busy_next | tag_v[k];
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      idle           <= 1'b1;
      bus.mem_en     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.out_valid  <= '0;
      bus.credit_err <= '0;
      rr             <= IW'(NSTREAMS - 1);
      tag_v          <= '0;
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        tag_id[k] <= '0;
      end
      for (int unsigned i = 0; i < NSTREAMS; i++) begin
        credit[i] <= CMAX;
        addr[i]   <= seg_base(i);
      end
    end else begin
      idle          <= ~busy_next;
      bus.mem_en    <= grant_any;
      bus.out_valid <= ret_onehot;
      if (grant_any) begin
        bus.mem_addr <= addr[grant_id];
        rr           <= grant_id;
      end
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_id;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      // Per-stream credit accounting and cyclic segment address.
      for (int unsigned i = 0; i < NSTREAMS; i++) begin
        if (issue[i] && !bus.credit_ret[i]) begin
          credit[i] <= credit[i] - CW'(1);
        end else if (!issue[i] && bus.credit_ret[i]) begin
          if (credit[i] == CMAX) begin
            bus.credit_err[i] <= 1'b1;
          end else begin
            credit[i] <= credit[i] + CW'(1);
          end
        end
        if (restart_apply) begin
          addr[i] <= seg_base(i);
        end else if (issue[i]) begin
          addr[i] <= (addr[i] == seg_last(i)) ? seg_base(i) : addr[i] + AWIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_memstream_credit_arbiter.sv
// Bench for memstream_credit_arbiter: expected reads queued by the stimulus,
// separate issue/return monitors pop and compare against DUT activity.
module tb_memstream_credit_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned CR  = 4;
  localparam logic [N*AW-1:0] OFFS = {14'd300, 14'd200, 14'd100, 14'd0};
  localparam logic [N*AW-1:0] DEPS = {14'd4,   14'd5,   14'd3,   14'd8};

  typedef struct { int s; logic [AW-1:0] a; } iss_t;
  typedef struct { int s; logic [DW-1:0] d; longint due; } ret_t;

  logic          aclk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          restart = 1'b0;
  logic          idle;
  logic [N-1:0]  ret_manual = '0;
  logic          echo = 1'b0;
  longint        cyc = 0;
  int            total = 0;
  int            passed = 0;
  iss_t          exp_issue[$];
  ret_t          exp_ret[$];
  logic [LAT-1:0] mpv = '0;
  logic [AW-1:0]  mpa [LAT];

  memstream_if #(.NSTREAMS(N), .AWIDTH(AW), .DWIDTH(DW)) bus ();

  memstream_credit_arbiter #(
    .NSTREAMS(N), .AWIDTH(AW), .DWIDTH(DW), .RD_LAT(LAT), .CREDITS(CR),
    .OFFSETS(OFFS), .DEPTHS(DEPS)
  ) dut (
    .aclk(aclk), .rst(rst), .run(run), .restart(restart), .idle(idle), .bus(bus)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {18'd0, a};
  endfunction

  // Memory model: data valid LAT cycles after the mem_en cycle.
  always @(posedge aclk) begin
    cyc    <= cyc + 1;
    mpv[0] <= bus.mem_en;
    mpa[0] <= bus.mem_addr;
    for (int k = 1; k < int'(LAT); k++) begin
      mpv[k] <= mpv[k-1];
      mpa[k] <= mpa[k-1];
    end
  end

  assign bus.mem_rdata  = mpv[LAT-1] ? mdata(mpa[LAT-1]) : 32'hDEAD_BEEF;
  assign bus.credit_ret = ret_manual | (echo ? bus.out_valid : '0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
  endtask

  task automatic exp_rd(input int s, input int a);
    iss_t e;
    e.s = s;
    e.a = AW'(a);
    exp_issue.push_back(e);
  endtask

  // Saturated rounds from a given starting point: s0..s3 each once per round.
  task automatic push_rounds(input int n);
    for (int r = 0; r < n; r++) begin
      exp_rd(0, r % 8);
      exp_rd(1, 100 + r % 3);
      exp_rd(2, 200 + r % 5);
      exp_rd(3, 300 + r % 4);
    end
  endtask

  // Issue monitor
  always @(posedge aclk) begin
    #1;
    if (bus.mem_en) begin
      if (exp_issue.size() == 0) begin
        total++;
        $display("FAIL spurious_issue: mem_addr=%0d while no read expected, cycle %0d",
                 bus.mem_addr, cyc);
      end else begin
        iss_t e;
        ret_t r;
        e = exp_issue.pop_front();
        chk("issue_addr", 64'(bus.mem_addr), 64'(e.a));
        r.s   = e.s;
        r.d   = mdata(e.a);
        r.due = cyc + longint'(LAT);
        exp_ret.push_back(r);
      end
    end
  end

  // Return monitor
  always @(posedge aclk) begin
    #1;
    if (bus.out_valid != '0) begin
      if (exp_ret.size() == 0) begin
        total++;
        $display("FAIL spurious_return: out_valid=%b while no word expected, cycle %0d",
                 bus.out_valid, cyc);
      end else begin
        ret_t r;
        logic [N-1:0] oh;
        r = exp_ret.pop_front();
        oh = '0;
        oh[r.s] = 1'b1;
        chk("ret_stream", 64'(bus.out_valid), 64'(oh));
        chk("ret_data", 64'(bus.out_data), 64'(r.d));
        chk("ret_cycle", 64'(cyc), 64'(r.due));
      end
    end
  end

  task automatic drain(input string nm);
    int i;
    i = 0;
    while (i < 80 && !(exp_issue.size() == 0 && exp_ret.size() == 0 && idle)) begin
      @(negedge aclk);
      i++;
    end
    chk({nm, "_issues_left"}, 64'(exp_issue.size()), 64'd0);
    chk({nm, "_returns_left"}, 64'(exp_ret.size()), 64'd0);
    chk({nm, "_idle"}, 64'(idle), 64'd1);
    chk({nm, "_mem_en"}, 64'(bus.mem_en), 64'd0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_idle"}, 64'(idle), 64'd1);
    chk({nm, "_mem_en"}, 64'(bus.mem_en), 64'd0);
    chk({nm, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({nm, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({nm, "_credit_err"}, 64'(bus.credit_err), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    rst = 1'b0;
    chk_reset("reset");

    // credit_ret at full credit: sticky error, count unchanged
    ret_manual = 4'b1000;
    @(negedge aclk);
    ret_manual = '0;
    chk("err_set", 64'(bus.credit_err), 64'd8);
    repeat (3) @(negedge aclk);
    chk("err_sticky", 64'(bus.credit_err), 64'd8);
    chk("paused_mem_en", 64'(bus.mem_en), 64'd0);

    // Full-credit burst: exactly 16 reads, s3 still has exactly CREDITS
    push_rounds(4);
    run = 1'b1;
    repeat (24) @(negedge aclk);
    drain("burst16");
    chk("addr_hold", 64'(bus.mem_addr), 64'd303);
    chk("err_after_burst", 64'(bus.credit_err), 64'd8);

    // Only stream 2 refilled, credit_ret[2] held: one read per cycle
    exp_rd(2, 204); exp_rd(2, 200); exp_rd(2, 201); exp_rd(2, 202);
    exp_rd(2, 203); exp_rd(2, 204); exp_rd(2, 200); exp_rd(2, 201);
    ret_manual = 4'b0100;
    repeat (8) @(negedge aclk);
    ret_manual = '0;
    drain("s2_only");
    chk("err_after_s2", 64'(bus.credit_err), 64'd8);

    // Reset, echoed credits, restart pulse while running (ignored)
    run = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge aclk);
    rst = 1'b0;
    chk_reset("reset2");
    echo = 1'b1;
    push_rounds(6);
    run = 1'b1;
    repeat (10) @(negedge aclk);
    restart = 1'b1;
    @(negedge aclk);
    restart = 1'b0;
    repeat (13) @(negedge aclk);
    run = 1'b0;
    drain("echo24");

    // Restart while idle and paused rewinds every stream
    restart = 1'b1;
    @(negedge aclk);
    restart = 1'b0;
    exp_rd(0, 0); exp_rd(1, 100); exp_rd(2, 200); exp_rd(3, 300);
    exp_rd(0, 1); exp_rd(1, 101);
    run = 1'b1;
    repeat (6) @(negedge aclk);
    run = 1'b0;
    drain("restart6");

    // Reset with two reads in flight drops them
    echo = 1'b0;
    exp_rd(2, 201); exp_rd(3, 301);
    run = 1'b1;
    repeat (2) @(negedge aclk);
    rst = 1'b1;
    run = 1'b0;
    exp_ret.delete();
    repeat (2) @(negedge aclk);
    rst = 1'b0;
    repeat (8) @(negedge aclk);
    chk_reset("reset3");
    chk("inflight_issues_left", 64'(exp_issue.size()), 64'd0);

    // Counters back at reset values: identical 16-read burst
    push_rounds(4);
    run = 1'b1;
    repeat (24) @(negedge aclk);
    run = 1'b0;
    drain("post_reset16");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
